inv_keyschedule: RTL
====================

INV_KEYSCHEDULE -- requirements
Module: inv_keyschedule

Interface
REQ-001 SHALL have no parameters; widths are fixed for AES-128 (11 round keys, 4 words, 32 bits).
REQ-002 eph1  input  1  single clock; all state updates on posedge eph1.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request; samples last_key.
REQ-005 last_key  input  128  round-10 key; word 3 = MSBs = FIPS w40.
REQ-006 SBOX  input  [255:0][7:0]  forward S-box; byte x is read as SBOX[255-x].
REQ-007 busy  output  1  high while round keys are being derived.
REQ-008 ready  output  1  high when all 11 round keys are valid.
REQ-009 key_words  output  [10:0][3:0][31:0]  round keys; index r = round r; [0] = recovered cipher key.

Function
REQ-010 States SHALL be IDLE, RUN and DONE; reset enters IDLE.
REQ-011 In IDLE or DONE, start SHALL load last_key into key_words[10] and into working register cur, set the round counter cnt=10, clear ready and enter RUN.
REQ-012 Each RUN cycle SHALL compute the previous key p from cur.
- p[0]=cur[0]^cur[1], p[1]=cur[1]^cur[2], p[2]=cur[2]^cur[3].
- p[3]=cur[3]^SubWord(RotWord(p[0]))^{rcon(cnt),24'h0}.
- RotWord(w)={w[2:0],w[3]} in bytes.
REQ-013 Each RUN cycle SHALL write p to key_words[cnt-1] and to cur, then decrement cnt.
REQ-014 rcon(cnt) for cnt=1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-015 When cnt==1 in RUN, the write SHALL fill key_words[0] and the next state SHALL be DONE.
REQ-016 Timing: start seen at edge N gives ready=1 after edge N+10; busy=1 from after edge N through edge N+10.
REQ-017 start during RUN SHALL be ignored; the derivation continues unchanged.
REQ-018 In DONE, key_words and ready SHALL hold until reset or a new start.
REQ-019 A new start in DONE SHALL drop ready on the next cycle and restart the derivation.
REQ-020 key_words entries not yet written in the current run SHALL keep their prior values; consumers use them only when ready=1.

Reset
REQ-021 Reset SHALL force the state to IDLE, busy=0, ready=0, cnt=0, cur=0 and all key_words=0, regardless of state.
REQ-022 Reset asserted mid-RUN SHALL abort the run; no partial key is flagged valid.

Configuration
REQ-023 Macro INV_KEY_EQUIV_EN, when defined, SHALL output InvMixColumns(key) on key_words[1..9], as the equivalent inverse cipher requires.
REQ-024 With INV_KEY_EQUIV_EN defined, key_words[0] and [10] SHALL stay untransformed, and the recursion SHALL still use the untransformed cur.
REQ-025 Without INV_KEY_EQUIV_EN, all key_words SHALL be plain FIPS-197 round keys and no InvMixColumns logic SHALL exist.
REQ-026 The latency SHALL be identical with and without INV_KEY_EQUIV_EN.

Structure
REQ-027 The shared package aes_hdr SHALL hold:
- the state enum (IDLE/RUN/DONE);
- the RCON table constant;
- typedefs word_t [3:0][7:0] and rkey_t [3:0][31:0].
REQ-028 The sub-module aes_inv_mixcolumns SHALL provide 128-bit combinational InvMixColumns and SHALL be instantiated only under INV_KEY_EQUIV_EN.
REQ-029 All registers SHALL use the codebase's standard register primitives, extended with an asynchronous reset.

Verification
REQ-030 Case 1: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 (macro off).
- ready rises 10 edges after start.
- key_words[0]=2b7e151628aed2a6abf7158809cf4f3c.
- key_words[9]=ac7766f319fadc2128d12941575c006e.
REQ-031 Case 2: the same stimulus with INV_KEY_EQUIV_EN defined.
- key_words[0] and key_words[10] are unchanged from Case 1.
- key_words[9]=InvMixColumns(ac7766f319fadc2128d12941575c006e).
REQ-032 Case 3: start pulses again at cycles +3 and +7 during RUN.
- Results and latency match Case 1.
- busy stays high throughout.
REQ-033 Case 4: reset asserted at cycle +5 after start.
- All outputs read 0 immediately, before the next edge.
- A new start then gives correct Case 1 results.
REQ-034 Case 5: in DONE, start with last_key=0.
- ready falls on the next cycle.
- After 10 cycles, ready=1 and key_words[0] is the key that expands to the all-zero round-10 key (cross-checked against the forward key expansion).

Source files
------------

// File: rtl/aes_hdr.sv
// Shared AES-128 types, round constants and byte helpers for the inverse key schedule.
package aes_hdr;

    typedef logic [3:0][7:0]   word_t;
    typedef logic [3:0][31:0]  rkey_t;
    typedef logic [255:0][7:0] sbox_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Entry 0 is a filler so the table can be indexed directly by the round counter.
    localparam logic [10:0][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10,
        8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] cnt);
        return (cnt <= 4'd10) ? RCON[cnt] : 8'h00;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[2:0], w[3]};
    endfunction

    // The S-box bus is packed with entry 0 at the top, so byte x lives at index 255-x.
    function automatic word_t sub_word(input word_t w, input sbox_t sbox);
        word_t r;
        for (int b = 0; b < 4; b++) begin
            r[b] = sbox[8'd255 - w[b]];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_dffre.sv
// Enabled D register with asynchronous active-high reset to zero.
module aes_dffre #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/aes_inv_mixcolumns.sv
// Combinational 128-bit InvMixColumns; only built when INV_KEY_EQUIV_EN is defined.
`ifdef INV_KEY_EQUIV_EN
module aes_inv_mixcolumns
    import aes_hdr::*;
(
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b  : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    // Byte 3 is the top row of the column, matching the FIPS word byte order.
    function automatic word_t inv_mix_word(input word_t a);
        word_t r;
        r[3] = gf_mul(a[3], 4'he) ^ gf_mul(a[2], 4'hb) ^ gf_mul(a[1], 4'hd) ^ gf_mul(a[0], 4'h9);
        r[2] = gf_mul(a[3], 4'h9) ^ gf_mul(a[2], 4'he) ^ gf_mul(a[1], 4'hb) ^ gf_mul(a[0], 4'hd);
        r[1] = gf_mul(a[3], 4'hd) ^ gf_mul(a[2], 4'h9) ^ gf_mul(a[1], 4'he) ^ gf_mul(a[0], 4'hb);
        r[0] = gf_mul(a[3], 4'hb) ^ gf_mul(a[2], 4'hd) ^ gf_mul(a[1], 4'h9) ^ gf_mul(a[0], 4'he);
        return r;
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign o_state[32*c +: 32] = inv_mix_word(i_state[32*c +: 32]);
    end

endmodule
`endif

// File: rtl/inv_keyschedule.sv
// AES-128 inverse key schedule: walks from the round-10 key back to the cipher key, one round per cycle.
// Optional INV_KEY_EQUIV_EN emits InvMixColumns'd keys on rounds 1..9 for the equivalent inverse cipher.
module inv_keyschedule
    import aes_hdr::*;
(
    input  logic                   eph1,
    input  logic                   reset,
    input  logic                   start,
    input  logic [127:0]           last_key,
    input  logic [255:0][7:0]      SBOX,
    output logic                   busy,
    output logic                   ready,
    output logic [10:0][3:0][31:0] key_words
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    rkey_t      r_cur;
    rkey_t      w_cur_nxt;
    rkey_t      w_prev;
    rkey_t      w_prev_mid;
    word_t      w_sub;
    logic       w_load;
    logic       w_step;

    assign w_load = start && (r_state != RUN);
    assign w_step = (r_state == RUN);

    assign w_prev[0] = r_cur[0] ^ r_cur[1];
    assign w_prev[1] = r_cur[1] ^ r_cur[2];
    assign w_prev[2] = r_cur[2] ^ r_cur[3];
    assign w_sub     = sub_word(rot_word(w_prev[0]), SBOX);
    assign w_prev[3] = r_cur[3] ^ w_sub ^ {rcon_of(r_cnt), 24'h0};

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_nxt   = r_cur;
        if (w_load) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 4'd10;
            w_cur_nxt   = last_key;
        end else if (w_step) begin
            w_cur_nxt = w_prev;
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                w_state_nxt = DONE;
            end
        end
    end

    aes_dffre #(.W(2)) u_state (
        .clk (eph1), .rst (reset), .en (1'b1), .d (w_state_nxt), .q (r_state)
    );

    aes_dffre #(.W(4)) u_cnt (
        .clk (eph1), .rst (reset), .en (w_load | w_step), .d (w_cnt_nxt), .q (r_cnt)
    );

    aes_dffre #(.W(128)) u_cur (
        .clk (eph1), .rst (reset), .en (w_load | w_step), .d (w_cur_nxt), .q (r_cur)
    );

    // The recursion always runs on the plain key in cur; only the stored copy is transformed.
`ifdef INV_KEY_EQUIV_EN
    aes_inv_mixcolumns u_imc (
        .i_state (w_prev),
        .o_state (w_prev_mid)
    );
`else
    assign w_prev_mid = w_prev;
`endif

    // NOTE: round keys are held in flops rather than a RAM, so they can and do clear on reset.
    for (genvar gi = 0; gi < 11; gi++) begin : g_kw
        rkey_t w_d;
        logic  w_en;
        if (gi == 10) begin : g_last
            assign w_en = w_load;
            assign w_d  = last_key;
        end else begin : g_rnd
            assign w_en = w_step && (r_cnt == 4'(gi + 1));
            if (gi == 0) begin : g_plain
                assign w_d = w_prev;
            end else begin : g_mid
                assign w_d = w_prev_mid;
            end
        end
        aes_dffre #(.W(128)) u_kw (
            .clk (eph1), .rst (reset), .en (w_en), .d (w_d), .q (key_words[gi])
        );
    end

    assign busy  = (r_state == RUN);
    assign ready = (r_state == DONE);

endmodule
